// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory handshake bundle for mem_port_arbiter
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic [DATA_W-1:0] if_rdata_o;
  logic              if_done_o;
  logic              d_req_i;
  logic              d_we_i;
  logic [ADDR_W-1:0] d_addr_i;
  logic [DATA_W-1:0] d_wdata_i;
  logic [DATA_W-1:0] d_rdata_o;
  logic              d_done_o;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              mem_ack_i;
  logic              stall_o;

  modport slave (
    input  if_req_i, if_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i, mem_rdata_i, mem_ack_i,
    output if_rdata_o, if_done_o, d_rdata_o, d_done_o, mem_req_o, mem_we_o, mem_addr_o,
           mem_wdata_o, stall_o
  );

  modport master (
    output if_req_i, if_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i, mem_rdata_i, mem_ack_i,
    input  if_rdata_o, if_done_o, d_rdata_o, d_done_o, mem_req_o, mem_we_o, mem_addr_o,
           mem_wdata_o, stall_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one variable-latency memory between fetch and data stages
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input logic                clk_i,
  input logic                rst_i,
  mem_port_arbiter_if.slave  bus
);

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  typedef enum logic [2:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    RESP_I,
    RESP_D
  } state_t;

  state_t            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_done_q, if_done_d;
  logic              d_done_q, d_done_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic [3:0]        starve_q, starve_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      starve_q    <= 4'd0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_done_q   <= if_done_d;
      d_done_q    <= d_done_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      starve_q    <= starve_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_done_d   = 1'b0;
    d_done_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    starve_d    = starve_q;

    case (state_q)
      IDLE: begin
        // Data wins unless a waiting fetch has already been passed over SMAX times.
        if (bus.d_req_i && (!bus.if_req_i || (starve_q < SMAX))) begin
          state_d     = BUSY_D;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.d_we_i;
          mem_addr_d  = {bus.d_addr_i[ADDR_W-1:2], 2'b00};
          mem_wdata_d = bus.d_we_i ? bus.d_wdata_i : '0;
          starve_d    = bus.if_req_i ? (starve_q + 4'd1) : 4'd0;
        end else if (bus.if_req_i) begin
          state_d     = BUSY_I;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = {bus.if_addr_i[ADDR_W-1:2], 2'b00};
          mem_wdata_d = '0;
          starve_d    = 4'd0;
        end
      end
      BUSY_I: begin
        if (bus.mem_ack_i) begin
          state_d    = RESP_I;
          mem_req_d  = 1'b0;
          if_done_d  = 1'b1;
          if_rdata_d = bus.mem_rdata_i;
        end
      end
      BUSY_D: begin
        if (bus.mem_ack_i) begin
          state_d   = RESP_D;
          mem_req_d = 1'b0;
          d_done_d  = 1'b1;
          if (!mem_we_q) begin
            d_rdata_d = bus.mem_rdata_i;
          end
        end
      end
      RESP_I, RESP_D: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  assign bus.mem_req_o   = mem_req_q;
  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_wdata_o = mem_wdata_q;
  assign bus.if_done_o   = if_done_q;
  assign bus.d_done_o    = d_done_q;
  assign bus.if_rdata_o  = if_rdata_q;
  assign bus.d_rdata_o   = d_rdata_q;

  // Done masks its own request so the pipeline advances in the completion cycle.
  assign bus.stall_o = (bus.if_req_i & ~if_done_q) | (bus.d_req_i & ~d_done_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SMAX = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [31:0] last_load = 32'h0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic drive_idle();
    bus.if_req_i    = 1'b0;
    bus.if_addr_i   = '0;
    bus.d_req_i     = 1'b0;
    bus.d_we_i      = 1'b0;
    bus.d_addr_i    = '0;
    bus.d_wdata_i   = '0;
    bus.mem_rdata_i = '0;
    bus.mem_ack_i   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.mem_req_o, bus.mem_we_o, bus.if_done_o, bus.d_done_o, bus.stall_o} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl got %b exp 00000",
               {bus.mem_req_o, bus.mem_we_o, bus.if_done_o, bus.d_done_o, bus.stall_o});
    end
    n_checks++;
    if ({bus.mem_addr_o, bus.mem_wdata_o, bus.if_rdata_o, bus.d_rdata_o} !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_data got %h %h %h %h exp all zero",
               bus.mem_addr_o, bus.mem_wdata_o, bus.if_rdata_o, bus.d_rdata_o);
    end
  endtask

  task automatic test_fetch();
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h0000_0006;
    #1;
    n_checks++;
    if (bus.stall_o !== 1'b1) begin
      n_fail++; $display("FAIL fetch_stall_c0 got %b exp 1", bus.stall_o);
    end
    @(negedge clk);
    n_checks++;
    if ({bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o} !== {2'b10, 32'h4, 32'h0}) begin
      n_fail++;
      $display("FAIL fetch_mem got req=%b we=%b addr=%h wd=%h exp req=1 we=0 addr=00000004 wd=0",
               bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o);
    end
    n_checks++;
    if (bus.stall_o !== 1'b1) begin
      n_fail++; $display("FAIL fetch_stall_c1 got %b exp 1", bus.stall_o);
    end
    bus.mem_ack_i   = 1'b1;
    bus.mem_rdata_i = 32'h2002_000A;
    @(negedge clk);
    bus.mem_ack_i   = 1'b0;
    bus.mem_rdata_i = 32'h0;
    n_checks++;
    if ({bus.if_done_o, bus.d_done_o, bus.mem_req_o, bus.if_rdata_o} !== {3'b100, 32'h2002_000A}) begin
      n_fail++;
      $display("FAIL fetch_done got done=%b ddone=%b req=%b rdata=%h exp 1 0 0 2002000a",
               bus.if_done_o, bus.d_done_o, bus.mem_req_o, bus.if_rdata_o);
    end
    #1;
    n_checks++;
    if (bus.stall_o !== 1'b0) begin
      n_fail++; $display("FAIL fetch_stall_c2 got %b exp 0", bus.stall_o);
    end
    bus.if_req_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.if_done_o, bus.mem_req_o} !== 2'b00) begin
      n_fail++; $display("FAIL fetch_pulse_width got done=%b req=%b exp 0 0", bus.if_done_o, bus.mem_req_o);
    end
  endtask

  task automatic test_load();
    logic [31:0] rd;
    rd = $urandom | 32'h1;
    bus.d_req_i  = 1'b1;
    bus.d_we_i   = 1'b0;
    bus.d_addr_i = 32'h10;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o, bus.stall_o, bus.d_done_o}
          !== {2'b10, 32'h10, 32'h0, 2'b10}) begin
        n_fail++;
        $display("FAIL load_busy_%0d got req=%b we=%b addr=%h wd=%h stall=%b done=%b exp 1 0 10 0 1 0", i,
                 bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o, bus.stall_o, bus.d_done_o);
      end
      bus.mem_ack_i   = (i == 3);
      bus.mem_rdata_i = (i == 3) ? rd : 32'hBAD0_0000;
    end
    @(negedge clk);
    bus.mem_ack_i = 1'b0;
    n_checks++;
    if ({bus.d_done_o, bus.if_done_o, bus.mem_req_o, bus.d_rdata_o} !== {3'b100, rd}) begin
      n_fail++;
      $display("FAIL load_done got done=%b ifdone=%b req=%b rdata=%h exp 1 0 0 %h",
               bus.d_done_o, bus.if_done_o, bus.mem_req_o, bus.d_rdata_o, rd);
    end
    last_load   = rd;
    bus.d_req_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.d_done_o !== 1'b0) begin
      n_fail++; $display("FAIL load_pulse_width got %b exp 0", bus.d_done_o);
    end
  endtask

  task automatic test_store();
    bus.d_req_i   = 1'b1;
    bus.d_we_i    = 1'b1;
    bus.d_addr_i  = 32'h20;
    bus.d_wdata_i = 32'hDEAD_BEEF;
    @(negedge clk);
    n_checks++;
    if ({bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o} !== {2'b11, 32'h20, 32'hDEAD_BEEF}) begin
      n_fail++;
      $display("FAIL store_busy got req=%b we=%b addr=%h wd=%h exp 1 1 20 deadbeef",
               bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o);
    end
    bus.mem_ack_i   = 1'b1;
    bus.mem_rdata_i = ~last_load;
    @(negedge clk);
    bus.mem_ack_i = 1'b0;
    n_checks++;
    if ({bus.d_done_o, bus.d_rdata_o} !== {1'b1, last_load}) begin
      n_fail++;
      $display("FAIL store_done got done=%b rdata=%h exp 1 %h", bus.d_done_o, bus.d_rdata_o, last_load);
    end
    bus.d_req_i = 1'b0;
    bus.d_we_i  = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_contention();
    string exp_order;
    string got;
    int    k;
    exp_order = "DDIDDI";
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h100;
    bus.d_req_i   = 1'b1;
    bus.d_we_i    = 1'b0;
    bus.d_addr_i  = 32'h200;
    for (int g = 0; g < 6; g++) begin
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (bus.mem_req_o !== 1'b1 && k < 10);
      n_checks++;
      if (bus.mem_req_o !== 1'b1) begin
        n_fail++; $display("FAIL contention_timeout grant %0d got no mem_req exp mem_req", g);
        got = "X";
      end else begin
        got = (bus.mem_addr_o == 32'h200) ? "D" : "I";
      end
      n_checks++;
      if (got != exp_order.substr(g, g)) begin
        n_fail++; $display("FAIL contention_order grant %0d got %s exp %s", g, got, exp_order.substr(g, g));
      end
      bus.mem_ack_i   = 1'b1;
      bus.mem_rdata_i = $urandom;
      @(negedge clk);
      bus.mem_ack_i = 1'b0;
      #1;
      n_checks++;
      if (bus.stall_o !== 1'b1) begin
        n_fail++; $display("FAIL contention_stall grant %0d got %b exp 1", g, bus.stall_o);
      end
    end
    bus.if_req_i = 1'b0;
    bus.d_req_i  = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bus.d_req_i  = 1'b1;
    bus.d_we_i   = 1'b0;
    bus.d_addr_i = 32'h40;
    @(negedge clk);
    n_checks++;
    if (bus.mem_req_o !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_busy got req=%b exp 1", bus.mem_req_o);
    end
    rst         = 1'b1;
    bus.d_req_i = 1'b0;
    @(negedge clk);
    rst             = 1'b0;
    bus.mem_ack_i   = 1'b1;
    bus.mem_rdata_i = 32'h5A5A_1234;
    n_checks++;
    if ({bus.mem_req_o, bus.d_done_o, bus.d_rdata_o, bus.if_rdata_o} !== 66'h0) begin
      n_fail++;
      $display("FAIL rstmid_after got req=%b done=%b drd=%h ird=%h exp all zero",
               bus.mem_req_o, bus.d_done_o, bus.d_rdata_o, bus.if_rdata_o);
    end
    @(negedge clk);
    bus.mem_ack_i = 1'b0;
    n_checks++;
    if ({bus.mem_req_o, bus.d_done_o, bus.d_rdata_o, bus.stall_o} !== 35'h0) begin
      n_fail++;
      $display("FAIL rstmid_late_ack got req=%b done=%b drd=%h stall=%b exp all zero",
               bus.mem_req_o, bus.d_done_o, bus.d_rdata_o, bus.stall_o);
    end
  endtask

  task automatic test_spurious_ack();
    for (int i = 0; i < 4; i++) begin
      bus.mem_ack_i   = 1'b1;
      bus.mem_rdata_i = $urandom;
      @(negedge clk);
      n_checks++;
      if ({bus.mem_req_o, bus.mem_we_o, bus.if_done_o, bus.d_done_o, bus.stall_o,
           bus.mem_addr_o, bus.mem_wdata_o, bus.if_rdata_o, bus.d_rdata_o} !== 133'h0) begin
        n_fail++;
        $display("FAIL spurious_ack_%0d got req=%b done=%b/%b ird=%h drd=%h exp all zero", i,
                 bus.mem_req_o, bus.if_done_o, bus.d_done_o, bus.if_rdata_o, bus.d_rdata_o);
      end
    end
    bus.mem_ack_i = 1'b0;
    @(negedge clk);
  endtask

  // Transaction-level model: each grant schedules its busy window, done cycle and next idle cycle.
  task automatic test_random(input int ncyc);
    int          grant_cyc, ack_cyc, free_cyc, kind, starve, ngrant;
    logic [31:0] pend, e_if_rd, e_d_rd, e_addr, e_wd;
    logic        e_we, e_req, e_ifd, e_dd, e_stall;
    grant_cyc = -100; ack_cyc = -100; free_cyc = 0; kind = 0; starve = 0; ngrant = 0;
    pend = 0; e_if_rd = 0; e_d_rd = 0; e_addr = 0; e_wd = 0; e_we = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      e_req = (kind != 0) && (c > grant_cyc) && (c <= ack_cyc);
      e_ifd = (kind == 1) && (c == ack_cyc + 1);
      e_dd  = (kind == 2) && (c == ack_cyc + 1);
      if (e_ifd) e_if_rd = pend;
      if (e_dd && !e_we) e_d_rd = pend;
      n_checks++;
      if ({bus.mem_req_o, bus.if_done_o, bus.d_done_o, bus.if_rdata_o, bus.d_rdata_o}
          !== {e_req, e_ifd, e_dd, e_if_rd, e_d_rd}) begin
        n_fail++;
        $display("FAIL rand_ctrl c=%0d got req=%b id=%b dd=%b ird=%h drd=%h exp %b %b %b %h %h", c,
                 bus.mem_req_o, bus.if_done_o, bus.d_done_o, bus.if_rdata_o, bus.d_rdata_o,
                 e_req, e_ifd, e_dd, e_if_rd, e_d_rd);
      end
      if (e_req) begin
        n_checks++;
        if ({bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o} !== {e_we, e_addr, e_wd}) begin
          n_fail++;
          $display("FAIL rand_fields c=%0d got we=%b addr=%h wd=%h exp %b %h %h", c,
                   bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o, e_we, e_addr, e_wd);
        end
      end
      if (e_ifd) begin
        if ($urandom_range(1) == 0) bus.if_req_i = 1'b0;
        else bus.if_addr_i = $urandom;
      end else if (!bus.if_req_i && $urandom_range(2) == 0) begin
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = $urandom;
      end
      if (e_dd) begin
        if ($urandom_range(1) == 0) bus.d_req_i = 1'b0;
        else begin
          bus.d_we_i = $urandom_range(1); bus.d_addr_i = $urandom; bus.d_wdata_i = $urandom;
        end
      end else if (!bus.d_req_i && $urandom_range(2) == 0) begin
        bus.d_req_i = 1'b1;
        bus.d_we_i = $urandom_range(1); bus.d_addr_i = $urandom; bus.d_wdata_i = $urandom;
      end
      if (c >= free_cyc && (bus.d_req_i || bus.if_req_i)) begin
        if (bus.d_req_i && (!bus.if_req_i || starve < SMAX)) begin
          kind   = 2;
          starve = bus.if_req_i ? starve + 1 : 0;
          e_we   = bus.d_we_i;
          e_addr = bus.d_addr_i & 32'hFFFF_FFFC;
          e_wd   = bus.d_we_i ? bus.d_wdata_i : 32'h0;
        end else begin
          kind   = 1;
          starve = 0;
          e_we   = 1'b0;
          e_addr = bus.if_addr_i & 32'hFFFF_FFFC;
          e_wd   = 32'h0;
        end
        grant_cyc = c;
        ack_cyc   = c + int'($urandom_range(4, 1));
        free_cyc  = ack_cyc + 2;
        ngrant++;
      end
      if (kind != 0 && c == ack_cyc) begin
        pend            = $urandom;
        bus.mem_ack_i   = 1'b1;
        bus.mem_rdata_i = pend;
      end else if (kind != 0 && c > grant_cyc && c < ack_cyc) begin
        bus.mem_ack_i   = 1'b0;
        bus.mem_rdata_i = $urandom;
      end else begin
        bus.mem_ack_i   = ($urandom_range(3) == 0);
        bus.mem_rdata_i = $urandom;
      end
      #1;
      e_stall = (bus.if_req_i & ~e_ifd) | (bus.d_req_i & ~e_dd);
      n_checks++;
      if (bus.stall_o !== e_stall) begin
        n_fail++; $display("FAIL rand_stall c=%0d got %b exp %b", c, bus.stall_o, e_stall);
      end
    end
    drive_idle();
    n_checks++;
    if (ngrant < 20) begin
      n_fail++; $display("FAIL rand_progress got %0d grants exp at least 20", ngrant);
    end
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_fetch();
    test_load();
    test_store();
    test_contention();
    test_reset_mid();
    test_spurious_ack();
    test_random(600);
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got time limit exp test completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer that shares one single-ported, variable-latency backing memory between the instruction-fetch stage and the MEM stage of the 5-stage pipeline CPU. It latches one request at a time, drives the memory handshake, returns read data with a one-cycle done pulse, and raises a pipeline-wide stall while any request is outstanding. Data accesses have priority, with a starvation counter that guarantees fetch progress.

## Interface
- ADDR_W, 32, address width of both requesters and the memory port
- DATA_W, 32, data width
- STARVE_MAX, 4, consecutive data grants allowed while a fetch waits; range 1..15

- clk_i  in  1  clock; all state changes on rising edge
- rst_i  in  1  reset, synchronous, active-high
- if_req_i  in  1  fetch request; held high until if_done_o is seen
- if_addr_i  in  ADDR_W  fetch address; stable while if_req_i is high
- if_rdata_o  out  DATA_W  fetched word; valid with if_done_o, held until the next fetch completes
- if_done_o  out  1  one-cycle completion pulse for fetch
- d_req_i  in  1  data request (MemRead | MemWrite); held until d_done_o
- d_we_i  in  1  1 = write, 0 = read
- d_addr_i  in  ADDR_W  data address (ALU result)
- d_wdata_i  in  DATA_W  store data
- d_rdata_o  out  DATA_W  load data; valid with d_done_o on reads, held otherwise
- d_done_o  out  1  one-cycle completion pulse for data
- mem_req_o  out  1  memory request; held until mem_ack_i
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_W  latched address with bits [1:0] forced to 0
- mem_wdata_o  out  DATA_W  latched store data; 0 for fetches and loads
- mem_rdata_i  in  DATA_W  memory read data; valid in the ack cycle
- mem_ack_i  in  1  memory completion; sampled only while mem_req_o = 1
- stall_o  out  1  pipeline freeze (PC, IF/ID, ID/EX, EX/MEM, MEM/WB hold)

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D.
- IDLE:
  - d_req_i = 1 and (if_req_i = 0 or starve_cnt < STARVE_MAX): latch d_we/d_addr/d_wdata, go to BUSY_D, and increment starve_cnt if if_req_i = 1.
  - Otherwise, if if_req_i = 1: latch if_addr, go to BUSY_I, and clear starve_cnt.
  - Otherwise: stay in IDLE.
- BUSY_x: mem_req_o = 1 with the latched fields. On mem_ack_i = 1, capture mem_rdata_i into if_rdata_o (BUSY_I) or into d_rdata_o (BUSY_D with we = 0), then go to RESP_x.
- RESP_x: the matching done output is 1 for exactly this cycle, mem_req_o = 0, requests are ignored, and the next state is IDLE.
- starve_cnt is 4 bits and saturates at STARVE_MAX. It clears on any fetch grant and on any data grant made while if_req_i = 0.
- stall_o = (if_req_i & ~if_done_o) | (d_req_i & ~d_done_o); combinational from the requests and the registered done outputs.
- Stores do not modify d_rdata_o.
- Request inputs are sampled only in IDLE. Changes to address or data while in BUSY/RESP are ignored.

## Timing
- All outputs except stall_o are registered.
- Reset values: state IDLE, mem_req_o 0, mem_we_o 0, mem_addr_o 0, mem_wdata_o 0, if_done_o 0, d_done_o 0, if_rdata_o 0, d_rdata_o 0, starve_cnt 0.
- Request seen in cycle N (IDLE) gives mem_req_o = 1 from cycle N+1.
- Ack in cycle M gives done = 1 in cycle M+1 and IDLE in M+2.
- Minimum access latency is 2 cycles (ack in N+1, done in N+2). Back-to-back accesses start no closer than 3 cycles apart.
- Simultaneous if_req and d_req in IDLE: data wins unless starve_cnt = STARVE_MAX, in which case fetch wins.
- mem_ack_i outside BUSY states is ignored, including an ack that arrives after reset.
- Reset mid-access (rst_i high in BUSY or RESP): next edge gives IDLE with mem_req_o 0. No done pulse is produced, and captured data is discarded (rdata outputs read 0).
- A request held high after its done pulse is treated as a new request in the following IDLE cycle.

## Test plan
- Fetch only, ack 1 cycle after request:
  - if_req = 1, if_addr = 0x0000_0006 at cycle 0 → mem_req_o = 1, mem_addr_o = 0x0000_0004 at cycle 1.
  - Ack with rdata 0x2002_000A at cycle 1 → if_done_o = 1 and if_rdata_o = 0x2002_000A at cycle 2.
  - stall_o = 1 in cycles 0–1 and 0 in cycle 2.
- Load with 3-cycle memory latency: d_req = 1, d_we = 0, addr 0x10 → mem_req_o high for 3 cycles, d_done_o 1 cycle after ack, d_rdata_o = the ack data, stall_o high throughout.
- Store: d_we = 1, addr 0x20, wdata 0xDEAD_BEEF → mem_we_o = 1 and mem_wdata_o = 0xDEAD_BEEF while mem_req_o is high; d_rdata_o is unchanged after d_done_o.
- Contention, STARVE_MAX = 2, d_req and if_req held continuously → grant order D, D, I, D, D, I; each fetch grant clears starve_cnt to 0.
- Reset in BUSY_D, then ack one cycle later → no d_done_o, mem_req_o = 0 after the reset edge, the late ack is ignored, and state stays IDLE.
- Spurious mem_ack_i = 1 in IDLE with no requests → no done pulse, no state change, all outputs hold their reset values.
